// File: rtl/ft_pkg.sv
// ft_pkg -- shared types and helpers for the FT601 RX pattern checker.
//
// Contents:
//   ft_state_e   checker state (IDLE, SYNC, CHECK)
//   FT_PAT_STEP  amount the base byte advances from one pattern word to the next
//   ft_pat_word  builds the pattern word {b+3, b+2, b+1, b} from base byte b
//
// The pattern is a byte ramp. Each byte lane wraps modulo 256 independently,
// so base 0xFC gives 0xFFFEFDFC and the next base is 0x00.
package ft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2
   } ft_state_e;

   localparam int FT_PAT_STEP = 4;

   // Each lane is a self-determined 8-bit sum, so it wraps on its own.
   function automatic logic [31:0] ft_pat_word(input logic [7:0] base);
      return {base + 8'd3, base + 8'd2, base + 8'd1, base};
   endfunction

endpackage

// File: rtl/ft_sat_cnt.sv
// ft_sat_cnt -- saturating up-counter with synchronous clear.
//
// Parameters:
//   WIDTH    counter width
// Ports:
//   wr_clk   clock
//   nrst     asynchronous active-low reset, clears the count
//   clr      synchronous clear; takes priority over inc
//   inc      count up by one; the count holds at all-ones
//   cnt      current count
module ft_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             wr_clk,
   input  logic             nrst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge wr_clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {WIDTH{1'b1}})) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ft_rx_checker.sv
// ft_rx_checker -- checks the FT601 RX FIFO stream against a byte-ramp pattern.
//
// Parameters:
//   WORD_CNT_W  width of word_cnt
//   ERR_CNT_W   width of err_cnt
// Ports:
//   wr_clk     clock; every register is in this one domain
//   nrst       asynchronous active-low reset
//   ft_ready   FT601 link up; reads stop as soon as it drops
//   chk_en     checker enable
//   clr        synchronous clear of counters, flags and captured words
//   rd_data    RX FIFO data, valid the cycle after rd_en
//   rd_empty   RX FIFO empty
//   rd_en      RX FIFO read strobe (combinational)
//   locked     high while the checker is in CHECK
//   err_flag   sticky mismatch flag
//   word_cnt   words checked in CHECK (saturating)
//   err_cnt    words rejected in SYNC or mismatched in CHECK (saturating)
//   bad_word   last mismatching word received in CHECK
//   exp_word   pattern value that was expected for bad_word
//   dbg_state  current checker state
//
// Build option:
//   FT_RX_CHK_RESYNC_EN  When defined, a CHECK mismatch reseeds the expected
//                        base from the received word if that word is a
//                        consistent ramp. Otherwise the checker drops back to
//                        SYNC. When undefined, the expected base always
//                        advances by FT_PAT_STEP and the checker stays in CHECK.
//
// Read handshake:
//   rd_en = chk_en & ft_ready & ~rd_empty & ~clr. Every cycle rd_en is high
//   pops one word. rd_vld is rd_en delayed by one cycle. When rd_vld is high,
//   rd_data holds the popped word and it is checked on that clock edge.
//   If clr is high in the same cycle, the word is dropped.
module ft_rx_checker
   import ft_pkg::*;
#(
   parameter int WORD_CNT_W = 32,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                  wr_clk,
   input  logic                  nrst,
   input  logic                  ft_ready,
   input  logic                  chk_en,
   input  logic                  clr,
   input  logic [31:0]           rd_data,
   input  logic                  rd_empty,
   output logic                  rd_en,
   output logic                  locked,
   output logic                  err_flag,
   output logic [WORD_CNT_W-1:0] word_cnt,
   output logic [ERR_CNT_W-1:0]  err_cnt,
   output logic [31:0]           bad_word,
   output logic [31:0]           exp_word,
   output ft_state_e             dbg_state
);

   localparam logic [7:0] STEP_B = 8'(FT_PAT_STEP);

   ft_state_e   state;
   ft_state_e   state_nxt;
   logic        rd_vld;
   logic [7:0]  exp_base;
   logic [7:0]  base_adv;
   logic [31:0] exp_pat;
   logic        consec;
   logic        sync_hit;
   logic        check_hit;
   logic        mismatch;
   logic        resync_lost;
   logic        word_inc;
   logic        err_inc;

   assign rd_en = chk_en & ft_ready & ~rd_empty & ~clr;

   always_ff @(posedge wr_clk or negedge nrst) begin
      if (!nrst) rd_vld <= 1'b0;
      else       rd_vld <= rd_en;
   end

   // A word is a consistent ramp if it equals the pattern built from its own low byte.
   assign consec  = (rd_data == ft_pat_word(rd_data[7:0]));
   assign exp_pat = ft_pat_word(exp_base);

   // A word that arrives in the same cycle as clr is dropped.
   assign sync_hit  = rd_vld & ~clr & (state == SYNC);
   assign check_hit = rd_vld & ~clr & (state == CHECK);
   assign mismatch  = check_hit & (rd_data != exp_pat);
   assign word_inc  = check_hit;
   assign err_inc   = (sync_hit & ~consec) | mismatch;

`ifdef FT_RX_CHK_RESYNC_EN
   assign base_adv    = (mismatch && consec) ? rd_data[7:0] + STEP_B : exp_base + STEP_B;
   assign resync_lost = mismatch & ~consec;
`else
   assign base_adv    = exp_base + STEP_B;
   assign resync_lost = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge wr_clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // When chk_en drops with a word still in flight, the state is held until
   // that word has been checked.
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = chk_en ? SYNC : IDLE;
      end else if (!chk_en && !rd_vld) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (chk_en) state_nxt = SYNC;
            SYNC:    if (rd_vld && consec) state_nxt = CHECK;
            CHECK:   if (resync_lost) state_nxt = SYNC;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      locked    = (state == CHECK);
      dbg_state = state;
   end

   // ---------------- datapath ----------------
   // exp_base is reseeded by the next SYNC word, so clr does not reset it.
   always_ff @(posedge wr_clk or negedge nrst) begin
      if (!nrst) begin
         exp_base <= 8'd0;
      end else if (sync_hit && consec) begin
         exp_base <= rd_data[7:0] + STEP_B;
      end else if (check_hit) begin
         exp_base <= base_adv;
      end
   end

   always_ff @(posedge wr_clk or negedge nrst) begin
      if (!nrst) begin
         err_flag <= 1'b0;
         bad_word <= 32'd0;
         exp_word <= 32'd0;
      end else if (clr) begin
         err_flag <= 1'b0;
         bad_word <= 32'd0;
         exp_word <= 32'd0;
      end else begin
         if (err_inc) err_flag <= 1'b1;
         if (mismatch) begin
            bad_word <= rd_data;
            exp_word <= exp_pat;
         end
      end
   end

   ft_sat_cnt #(.WIDTH(WORD_CNT_W)) u_word_cnt (
      .wr_clk (wr_clk),
      .nrst   (nrst),
      .clr    (clr),
      .inc    (word_inc),
      .cnt    (word_cnt)
   );

   ft_sat_cnt #(.WIDTH(ERR_CNT_W)) u_err_cnt (
      .wr_clk (wr_clk),
      .nrst   (nrst),
      .clr    (clr),
      .inc    (err_inc),
      .cnt    (err_cnt)
   );

endmodule

// File: tb/tb_ft_rx_checker.sv
// tb_ft_rx_checker -- self-checking bench for ft_rx_checker.
// The bench builds the checker with narrow counters so that saturation can be
// reached quickly. The RX FIFO is modelled as a queue. A word-level reference
// model follows the checker rules from the words actually delivered.
module tb_ft_rx_checker;
   import ft_pkg::*;

   localparam int WC_W = 8;
   localparam int EC_W = 4;

   logic            wr_clk = 1'b0;
   logic            nrst;
   logic            ft_ready;
   logic            chk_en;
   logic            clr;
   logic [31:0]     rd_data;
   logic            rd_empty;
   logic            rd_en;
   logic            locked;
   logic            err_flag;
   logic [WC_W-1:0] word_cnt;
   logic [EC_W-1:0] err_cnt;
   logic [31:0]     bad_word;
   logic [31:0]     exp_word;
   ft_state_e       dbg_state;

   int n_vec = 0;
   int n_bad = 0;

   ft_rx_checker #(.WORD_CNT_W(WC_W), .ERR_CNT_W(EC_W)) dut (
      .wr_clk    (wr_clk),
      .nrst      (nrst),
      .ft_ready  (ft_ready),
      .chk_en    (chk_en),
      .clr       (clr),
      .rd_data   (rd_data),
      .rd_empty  (rd_empty),
      .rd_en     (rd_en),
      .locked    (locked),
      .err_flag  (err_flag),
      .word_cnt  (word_cnt),
      .err_cnt   (err_cnt),
      .bad_word  (bad_word),
      .exp_word  (exp_word),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 wr_clk = ~wr_clk;

   // ---------------- FIFO model and stimulus knobs ----------------
   logic [31:0] fifo_q[$];
   logic        took;
   logic [31:0] held;
   logic        stall_en;
   logic        ready_noise;

   // ---------------- reference model ----------------
   ft_state_e   m_state;
   int          m_base;
   logic [7:0]  m_wc;
   logic [3:0]  m_ec;
   logic        m_flag;
   logic [31:0] m_bad;
   logic [31:0] m_exp;

   function automatic logic [31:0] pat(input int b);
      logic [31:0] w;
      w = 32'd0;
      for (int k = 0; k < 4; k++) w = w | (32'((b + k) % 256) << (8 * k));
      return w;
   endfunction

   function automatic void model_reset();
      m_state = IDLE;
      m_base  = 0;
      m_wc    = 8'd0;
      m_ec    = 4'd0;
      m_flag  = 1'b0;
      m_bad   = 32'd0;
      m_exp   = 32'd0;
   endfunction

   function automatic void model_err();
      if (m_ec != 4'hF) m_ec = m_ec + 4'd1;
      m_flag = 1'b1;
   endfunction

   function automatic void model_feed(input logic [31:0] w);
      int          b;
      logic        consec;
      logic [31:0] e;
      b      = int'(w[7:0]);
      consec = (w == pat(b));
      if (m_state == SYNC) begin
         if (consec) begin
            m_base  = (b + 4) % 256;
            m_state = CHECK;
         end else begin
            model_err();
         end
      end else if (m_state == CHECK) begin
         if (m_wc != 8'hFF) m_wc = m_wc + 8'd1;
         e = pat(m_base);
         if (w != e) begin
            model_err();
            m_bad = w;
            m_exp = e;
`ifdef FT_RX_CHK_RESYNC_EN
            if (consec) m_base = (b + 4) % 256;
            else        m_state = SYNC;
`else
            m_base = (m_base + 4) % 256;
`endif
         end else begin
            m_base = (m_base + 4) % 256;
         end
      end
   endfunction

   function automatic logic [79:0] obs_vec();
      return {dbg_state, locked, err_flag, word_cnt, err_cnt, bad_word, exp_word};
   endfunction

   function automatic logic [79:0] exp_vec();
      return {m_state, (m_state == CHECK), m_flag, m_wc, m_ec, m_bad, m_exp};
   endfunction

   // ---------------- driver ----------------
   // One clock cycle. Inputs change at the falling edge. A word popped on a
   // rd_en cycle is presented on rd_data at the next falling edge.
   task automatic step(input logic en_v, input logic clr_v);
      logic exp_rd;
      @(negedge wr_clk);
      chk_en = en_v;
      clr    = clr_v;
      if (took) begin
         rd_data = held;
         if (!clr_v) model_feed(held);
      end
      if (clr_v) begin
         m_state = en_v ? SYNC : IDLE;
         m_wc = 8'd0; m_ec = 4'd0; m_flag = 1'b0; m_bad = 32'd0; m_exp = 32'd0;
      end else if (!en_v) begin
         m_state = IDLE;
      end else if (m_state == IDLE) begin
         m_state = SYNC;
      end
      rd_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
      ft_ready = ready_noise ? ($urandom_range(0, 4) != 0) : 1'b1;
      #1;
      exp_rd = en_v & ft_ready & ~rd_empty & ~clr_v;
      n_vec++;
      if (rd_en !== exp_rd) begin
         n_bad++;
         $display("FAIL rd_en: got %b want %b", rd_en, exp_rd);
      end
      took = rd_en && (fifo_q.size() != 0);
      if (took) held = fifo_q.pop_front();
   endtask

   // Run until the FIFO is empty and no word is in flight, then let the DUT settle.
   task automatic drain(input string name);
      int budget;
      budget = 3000;
      while (budget > 0 && (took || (chk_en && fifo_q.size() != 0))) begin
         step(chk_en, 1'b0);
         budget--;
      end
      if (budget == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: got %0d queued words, required 0", name, fifo_q.size());
      end
      step(chk_en, 1'b0);
      step(chk_en, 1'b0);
      @(posedge wr_clk);
      #1;
   endtask

   task automatic push_ramp(input int b0, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(pat(b0 + 4 * i));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nrst = 1'b0; chk_en = 1'b0; clr = 1'b0; ft_ready = 1'b1;
      rd_empty = 1'b1; rd_data = 32'd0; took = 1'b0; held = 32'd0;
      stall_en = 1'b0; ready_noise = 1'b0;
      model_reset();
      repeat (3) @(posedge wr_clk);
      #1;
      n_vec++;
      if (obs_vec() !== 80'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want %h", obs_vec(), 80'd0);
      end
      @(negedge wr_clk);
      nrst = 1'b1;
   endtask

   task automatic test_clean_stream();
      stall_en = 1'b1; ready_noise = 1'b1;
      push_ramp(0, 100);
      step(1'b1, 1'b0);
      drain("clean");
      stall_en = 1'b0; ready_noise = 1'b0;
      n_vec++;
      if (word_cnt !== 8'd99 || err_cnt !== 4'd0 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL clean_counts: got wc=%0d ec=%0d locked=%b want wc=99 ec=0 locked=1",
                  word_cnt, err_cnt, locked);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL clean_model: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap();
      step(1'b1, 1'b1);
      fifo_q.push_back(32'hFFFEFDFC);
      fifo_q.push_back(32'h03020100);
      drain("wrap");
      n_vec++;
      if (err_cnt !== 4'd0 || locked !== 1'b1 || word_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL wrap: got ec=%0d locked=%b wc=%0d want ec=0 locked=1 wc=1",
                  err_cnt, locked, word_cnt);
      end
   endtask

   task automatic test_corrupt();
      step(1'b1, 1'b1);
      push_ramp(0, 4);
      fifo_q.push_back(32'h23222120);
`ifdef FT_RX_CHK_RESYNC_EN
      fifo_q.push_back(32'h27262524);
      fifo_q.push_back(pat(8'h28));
`else
      fifo_q.push_back(32'h17161514);
      fifo_q.push_back(pat(8'h18));
`endif
      drain("corrupt");
      n_vec++;
      if (err_cnt !== 4'd1 || err_flag !== 1'b1 || bad_word !== 32'h23222120 ||
          exp_word !== 32'h13121110 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL corrupt: got ec=%0d flag=%b bad=%h exp=%h locked=%b want 1 1 23222120 13121110 1",
                  err_cnt, err_flag, bad_word, exp_word, locked);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL corrupt_model: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_clr_inflight();
      fifo_q.push_back(pat(m_base));
      for (int i = 0; i < 20 && !took; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      @(posedge wr_clk);
      #1;
      n_vec++;
      if (word_cnt !== 8'd0 || err_cnt !== 4'd0 || err_flag !== 1'b0 || dbg_state !== SYNC) begin
         n_bad++;
         $display("FAIL clr_inflight: got wc=%0d ec=%0d flag=%b st=%0d want 0 0 0 SYNC",
                  word_cnt, err_cnt, err_flag, dbg_state);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL clr_model: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_sync_error();
      step(1'b1, 1'b1);
      fifo_q.push_back(32'h00000001);
      drain("sync_err");
      n_vec++;
      if (err_cnt !== 4'd1 || locked !== 1'b0 || err_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL sync_err: got ec=%0d locked=%b flag=%b want 1 0 1", err_cnt, locked, err_flag);
      end
      fifo_q.push_back(32'h0B0A0908);
      fifo_q.push_back(32'h0F0E0D0C);
      drain("sync_lock");
      n_vec++;
      if (locked !== 1'b1 || err_cnt !== 4'd1 || word_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL sync_lock: got locked=%b ec=%0d wc=%0d want 1 1 1", locked, err_cnt, word_cnt);
      end
   endtask

   task automatic test_saturation();
      step(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) fifo_q.push_back(32'h00000001);
      drain("sat_err");
      n_vec++;
      if (err_cnt !== 4'hF) begin
         n_bad++;
         $display("FAIL err_saturate: got %0d want 15", err_cnt);
      end
      push_ramp(0, 300);
      drain("sat_word");
      n_vec++;
      if (word_cnt !== 8'hFF || err_cnt !== 4'hF) begin
         n_bad++;
         $display("FAIL word_saturate: got wc=%0d ec=%0d want 255 15", word_cnt, err_cnt);
      end
   endtask

   task automatic test_random();
      int b;
      for (int r = 0; r < 3; r++) begin
         step(1'b1, 1'b1);
         stall_en = 1'b1; ready_noise = 1'b1;
         b = $urandom_range(0, 255);
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
               fifo_q.push_back($urandom_range(0, 1) ? $urandom() : pat($urandom_range(0, 255)));
            else
               fifo_q.push_back(pat(b));
            b = (b + 4) % 256;
         end
         drain("random");
         stall_en = 1'b0; ready_noise = 1'b0;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_model[%0d]: got %h want %h", r, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_disable_reset();
      step(1'b1, 1'b1);
      fifo_q.push_back(pat(8'h40));
      drain("dis_seed");
      push_ramp(8'h44, 3);
      for (int i = 0; i < 20 && !took; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      drain("dis_inflight");
      n_vec++;
      if (word_cnt !== 8'd1 || dbg_state !== IDLE || locked !== 1'b0) begin
         n_bad++;
         $display("FAIL disable_inflight: got wc=%0d st=%0d locked=%b want 1 IDLE 0",
                  word_cnt, dbg_state, locked);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL disable_model: got %h want %h", obs_vec(), exp_vec());
      end
      // Re-enable so that words flow again, then assert reset between clock edges.
      push_ramp(8'h50, 6);
      repeat (3) step(1'b1, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if (obs_vec() !== 80'd0) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", obs_vec(), 80'd0);
      end
      fifo_q.delete();
      took   = 1'b0;
      chk_en = 1'b0;
      @(negedge wr_clk);
      nrst = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      @(posedge wr_clk);
      #1;
      n_vec++;
      if (obs_vec() !== 80'd0) begin
         n_bad++;
         $display("FAIL reset_release: got %h want %h", obs_vec(), 80'd0);
      end
      push_ramp(8'h80, 5);
      step(1'b1, 1'b0);
      drain("restart");
      n_vec++;
      if (word_cnt !== 8'd4 || err_cnt !== 4'd0 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL restart: got wc=%0d ec=%0d locked=%b want 4 0 1", word_cnt, err_cnt, locked);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_clean_stream();
      test_wrap();
      test_corrupt();
      test_clr_inflight();
      test_sync_error();
      test_saturation();
      test_random();
      test_disable_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
